// File: rtl/ifetch_pkg.sv
// ----------------------------------------------------------------------------
// ifetch_pkg
// Shared types for the instruction fetch stage:
//   ifetch_state_e  - fetch sequencer states (BOOT, FETCH, FLUSH)
//   ifetch_entry_t  - one prefetch buffer entry, the word together with its PC
//   INSTR_BYTES     - byte stride between consecutive instruction words
//   align_pc()      - forces a byte address onto a word boundary
// ----------------------------------------------------------------------------
package ifetch_pkg;

   localparam int INSTR_BYTES = 4;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      FLUSH = 2'd2
   } ifetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ifetch_entry_t;

   // Redirect targets may carry junk in the two byte-offset bits; fetches are
   // always whole words, so those bits are simply dropped.
   function automatic logic [31:0] align_pc(input logic [31:0] pc);
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// ----------------------------------------------------------------------------
// ifetch_fifo
// Small synchronous FIFO holding fetched instruction words with their PC.
// Push and pop may happen in the same cycle at any occupancy, including full.
// A clear empties the FIFO on the next edge and overrides push/pop.
//
// Parameters:
//   DEPTH     number of entries, power of two, >= 2
// Ports:
//   clk       clock
//   rst       asynchronous active-high reset, empties the FIFO
//   push      write wr_entry at the tail
//   wr_entry  entry to write
//   pop       drop the head entry
//   clear     discard all entries
//   rd_entry  head entry (meaningful when !empty)
//   count     number of valid entries, 0..DEPTH
//   empty     count == 0
//   full      count == DEPTH
// ----------------------------------------------------------------------------
module ifetch_fifo
   import ifetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  ifetch_entry_t            wr_entry,
   input  logic                     pop,
   input  logic                     clear,
   output ifetch_entry_t            rd_entry,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   ifetch_entry_t    mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // A pop frees the head slot in the same edge, so a push into a full FIFO
   // is fine as long as a pop accompanies it.
   always_comb begin
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
   end

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign rd_entry = mem[rd_ptr];

   // Pointer and occupancy bookkeeping; clear takes priority over any
   // concurrent push or pop so a redirect never lets a stale word through.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Entry storage carries no reset; the pointers alone decide what is valid.
   always_ff @(posedge clk) begin
      if (do_push && !clear) begin
         mem[wr_ptr] <= wr_entry;
      end
   end

   // The upstream credit scheme must never offer a word with nowhere to go.
   assert property (@(posedge clk) disable iff (rst)
      !(push && full && !pop && !clear));

endmodule

// File: rtl/instr_fetch.sv
// ----------------------------------------------------------------------------
// instr_fetch
// Instruction fetch stage sitting in front of the instruction port of the
// on-chip memory. It issues sequential word fetches from a PC, tracks how many
// requests are still in flight, buffers returned words together with their PC
// in a small FIFO and hands them to decode over a valid/ready interface.
// A redirect (branch, jump, trap) drops everything buffered and makes any
// words still in flight be thrown away when they come back.
//
// Parameters:
//   RESET_PC     PC of the first fetch after reset
//   FIFO_DEPTH   prefetch entries (power of two, >= 2); also the cap on
//                in-flight plus buffered words
// Ports:
//   i_clk          clock
//   i_rst          asynchronous active-high reset
//   o_instr_addr   word-aligned fetch address
//   o_instr_req    fetch request, one word per asserted cycle
//   i_instr_data   returned instruction word
//   i_instr_ack    response valid, in request order, no backpressure
//   i_redirect     flush and restart fetching at i_redirect_pc
//   i_redirect_pc  new PC, low two bits ignored
//   o_if_valid     head entry valid towards decode
//   o_if_instr     head entry instruction word
//   o_if_pc        head entry PC
//   i_if_ready     decode takes the head entry when valid & ready
// Optional (macro IFETCH_PERF_CNT_EN):
//   o_fetch_cnt    wrapping count of decode handshakes
//   o_discard_cnt  wrapping count of responses dropped while flushing
// ----------------------------------------------------------------------------
module instr_fetch
   import ifetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic [31:0] o_instr_addr,
   output logic        o_instr_req,
   input  logic [31:0] i_instr_data,
   input  logic        i_instr_ack,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_if_valid,
   output logic [31:0] o_if_instr,
   output logic [31:0] o_if_pc,
   input  logic        i_if_ready
`ifdef IFETCH_PERF_CNT_EN
   ,
   output logic [31:0] o_fetch_cnt,
   output logic [31:0] o_discard_cnt
`endif
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int SW = CW + 1;

   ifetch_state_e  state;
   logic [31:0]    fetch_pc;
   logic [31:0]    resp_pc;
   logic [CW-1:0]  outstanding;
   logic [CW-1:0]  out_next;

   logic [CW-1:0]  fifo_count;
   logic           fifo_empty;
   logic           fifo_full;
   ifetch_entry_t  head;
   ifetch_entry_t  new_entry;

   logic           credit_ok;
   logic           issue;
   logic           ack_valid;
   logic           push;
   logic           pop;

   // Every word either sits in the FIFO or is still on its way back, so
   // keeping their sum below the depth guarantees a free slot for each
   // response. The sum is one bit wider than either operand so it cannot wrap.
   always_comb begin
      credit_ok = (({1'b0, fifo_count} + {1'b0, outstanding}) < SW'(FIFO_DEPTH));
      issue     = (state == FETCH) && !i_redirect && credit_ok;
   end

   assign o_instr_req  = issue;
   assign o_instr_addr = fetch_pc;

   // A response with nothing outstanding can only be a leftover from before
   // a reset; it is ignored rather than allowed to underflow the counter.
   // Responses are only kept while fetching and not being redirected; in
   // FLUSH they belong to the abandoned stream.
   always_comb begin
      ack_valid = i_instr_ack && (outstanding != '0);
      push      = ack_valid && (state == FETCH) && !i_redirect;
      pop       = o_if_valid && i_if_ready && !i_redirect;
   end

   // In-flight count after this cycle: a request and a response in the same
   // cycle cancel out.
   always_comb begin
      out_next = outstanding;
      unique case ({issue, ack_valid})
         2'b10:   out_next = outstanding + CW'(1);
         2'b01:   out_next = outstanding - CW'(1);
         default: out_next = outstanding;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         outstanding <= '0;
      end else begin
         outstanding <= out_next;
      end
   end

   // Sequencer. BOOT is a single idle cycle after reset. A redirect that
   // leaves words in flight parks the stage in FLUSH until the last of them
   // has returned; looking at the post-cycle count lets fetching resume in
   // the very cycle after the final stale response instead of one later.
   // A redirect while already flushing keeps flushing, only the PC changes.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state <= BOOT;
      end else begin
         unique case (state)
            BOOT: begin
               state <= FETCH;
            end
            FETCH, FLUSH: begin
               if ((i_redirect || state == FLUSH) && out_next != '0) begin
                  state <= FLUSH;
               end else begin
                  state <= FETCH;
               end
            end
            default: begin
               state <= BOOT;
            end
         endcase
      end
   end

   // Two PCs advance independently: fetch_pc follows issued requests and
   // resp_pc tags returning words. Both wrap naturally at 2^32 and both jump
   // to the aligned redirect target together.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         fetch_pc <= RESET_PC;
         resp_pc  <= RESET_PC;
      end else if (i_redirect) begin
         fetch_pc <= align_pc(i_redirect_pc);
         resp_pc  <= align_pc(i_redirect_pc);
      end else begin
         if (issue) begin
            fetch_pc <= fetch_pc + 32'(INSTR_BYTES);
         end
         if (push) begin
            resp_pc <= resp_pc + 32'(INSTR_BYTES);
         end
      end
   end

   assign new_entry = '{pc: resp_pc, instr: i_instr_data};

   ifetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (i_clk),
      .rst      (i_rst),
      .push     (push),
      .wr_entry (new_entry),
      .pop      (pop),
      .clear    (i_redirect),
      .rd_entry (head),
      .count    (fifo_count),
      .empty    (fifo_empty),
      .full     (fifo_full)
   );

   assign o_if_valid = !fifo_empty;
   assign o_if_pc    = head.pc;
   assign o_if_instr = head.instr;

`ifdef IFETCH_PERF_CNT_EN
   logic discard;

   assign discard = ack_valid && (state == FLUSH);

   // Handshakes swallowed by a simultaneous redirect are not counted, since
   // that entry never really reaches decode.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_fetch_cnt   <= '0;
         o_discard_cnt <= '0;
      end else begin
         if (pop) begin
            o_fetch_cnt <= o_fetch_cnt + 32'd1;
         end
         if (discard) begin
            o_discard_cnt <= o_discard_cnt + 32'd1;
         end
      end
   end
`endif

   // Bookkeeping sanity: never more words in flight than the FIFO can hold,
   // and never a response landing on a full FIFO without a pop to make room.
   assert property (@(posedge i_clk) disable iff (i_rst)
      outstanding <= CW'(FIFO_DEPTH));

   assert property (@(posedge i_clk) disable iff (i_rst)
      !(push && fifo_full && !pop));

endmodule
